// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage hazard and interlock unit for the MIPS core.
// Tracks in-flight register writes for the stages after D in a shift-register
// scoreboard (slot 1 = E ... slot STAGES = W), runs the MDU latency counter and
// the eret/EPC interlock, and produces stall, forwarding selects, mdu_busy and
// a saturating count of stalled cycles.
module hazard_scoreboard #(
    parameter int STAGES      = 3,
    parameter int TNEW_W      = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32,
    parameter int SEL_W       = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              D_valid,
    input  logic [4:0]        D_rs,
    input  logic [4:0]        D_rt,
    input  logic [TNEW_W-1:0] D_T_use_rs,
    input  logic [TNEW_W-1:0] D_T_use_rt,
    input  logic [4:0]        D_dst,
    input  logic              D_regwrite,
    input  logic [TNEW_W-1:0] D_T_new,
    input  logic [1:0]        D_md_op,
    input  logic              D_is_eret,
    input  logic              D_is_mtc0_epc,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // MDU counter must hold the longer of the two latencies.
    localparam int MDU_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MDU_W   = $clog2(MDU_MAX + 1);

    localparam logic [MDU_W-1:0] MULT_LOAD = MDU_W'(MULT_CYCLES);
    localparam logic [MDU_W-1:0] DIV_LOAD  = MDU_W'(DIV_CYCLES);

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    // One scoreboard entry per tracked stage.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [4:0]        dst;
        logic [TNEW_W-1:0] tnew;
        logic              mtc0_epc;
    } slot_t;

    // Result of the youngest-producer search for one source operand.
    typedef struct packed {
        logic              hit;
        logic [SEL_W-1:0]  sel;
        logic [TNEW_W-1:0] tnew;
    } match_t;

    slot_t [STAGES:1] slot_q;
    slot_t [STAGES:1] slot_d;

    logic [MDU_W-1:0] mdu_cnt_q;
    logic [MDU_W-1:0] mdu_cnt_d;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    match_t rs_m;
    match_t rt_m;
    logic   rs_stall;
    logic   rt_stall;
    logic   mdu_stall;
    logic   eret_stall;
    logic   epc_pending;
    logic   advance;

    // Youngest (smallest slot index) valid writer of src; $0 never matches.
    // Scanning from the oldest slot lets a younger match overwrite an older one,
    // which is exactly the shadowing rule.
    function automatic match_t find_youngest(input slot_t [STAGES:1] slots,
                                             input logic [4:0]      src);
        match_t m;
        m = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (slots[k].valid && slots[k].regwrite &&
                (slots[k].dst == src) && (src != 5'd0)) begin
                m.hit  = 1'b1;
                m.sel  = SEL_W'(k);
                m.tnew = slots[k].tnew;
            end
        end
        return m;
    endfunction

    // Locate the youngest producer of each D-stage source operand.
    always_comb begin
        rs_m = find_youngest(slot_q, D_rs);
        rt_m = find_youngest(slot_q, D_rt);
    end

    // Pending EPC write in any slot before the last one blocks eret; by the
    // last slot the EPC has been written and the eret may proceed.
    always_comb begin
        epc_pending = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            if (slot_q[k].valid && slot_q[k].mtc0_epc) begin
                epc_pending = 1'b1;
            end
        end
    end

    // Stall sources combine into the D-stage stall; req overrides all of them.
    always_comb begin
        rs_stall   = rs_m.hit && (rs_m.tnew > D_T_use_rs);
        rt_stall   = rt_m.hit && (rt_m.tnew > D_T_use_rt);
        mdu_stall  = D_valid && (D_md_op != MD_NONE) && (mdu_cnt_q != '0);
        eret_stall = D_is_eret && epc_pending;
        stall      = D_valid && !req && (rs_stall || rt_stall || mdu_stall || eret_stall);
        advance    = D_valid && !stall && !req;
    end

    // Shift the scoreboard one stage, ageing tnew toward zero; slot 1 takes
    // the D instruction when it advances, otherwise a bubble. req flushes all.
    always_comb begin
        slot_d = '0;
        for (int k = 2; k <= STAGES; k++) begin
            slot_d[k] = slot_q[k-1];
            if (slot_q[k-1].tnew != '0) begin
                slot_d[k].tnew = slot_q[k-1].tnew - TNEW_W'(1);
            end
        end
        if (advance) begin
            slot_d[1].valid    = 1'b1;
            slot_d[1].regwrite = D_regwrite;
            slot_d[1].dst      = D_dst;
            slot_d[1].tnew     = D_T_new;
            slot_d[1].mtc0_epc = D_is_mtc0_epc;
        end
        if (req) begin
            slot_d = '0;
        end
    end

    // MDU latency: count down while busy; a start op leaving D reloads the
    // counter and wins over the decrement. req does not stop a running op.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
        end
        if (advance) begin
            if (D_md_op == MD_MULT) begin
                mdu_cnt_d = MULT_LOAD;
            end else if (D_md_op == MD_DIV) begin
                mdu_cnt_d = DIV_LOAD;
            end
        end
    end

    // Count stalled cycles, holding at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset clears the scoreboard, MDU count and stall count.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= '0;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_rs_sel = rs_m.sel;
    assign fwd_rt_sel = rt_m.sel;
    assign mdu_busy   = (mdu_cnt_q != '0);
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table for the documented hazard
// scenarios, then randomized traffic compared against an in-flight-list model.
// A second instance with a 4-bit stall counter sees the same stimulus.
module tb_hazard_scoreboard;

    localparam int STAGES = 3;
    localparam int EXP_W  = 42;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        D_valid;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_T_use_rs;
    logic [1:0]  D_T_use_rt;
    logic [4:0]  D_dst;
    logic        D_regwrite;
    logic [1:0]  D_T_new;
    logic [1:0]  D_md_op;
    logic        D_is_eret;
    logic        D_is_mtc0_epc;

    logic        stall;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic        mdu_busy;
    logic [31:0] stall_cnt;

    logic        stall_s;
    logic [1:0]  fwd_rs_sel_s;
    logic [1:0]  fwd_rt_sel_s;
    logic        mdu_busy_s;
    logic [3:0]  stall_cnt_s;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .STAGES(3), .TNEW_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .D_valid(D_valid),
        .D_rs(D_rs), .D_rt(D_rt), .D_T_use_rs(D_T_use_rs), .D_T_use_rt(D_T_use_rt),
        .D_dst(D_dst), .D_regwrite(D_regwrite), .D_T_new(D_T_new), .D_md_op(D_md_op),
        .D_is_eret(D_is_eret), .D_is_mtc0_epc(D_is_mtc0_epc),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(
        .STAGES(3), .TNEW_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)
    ) dut_sat (
        .clk(clk), .reset(reset), .req(req), .D_valid(D_valid),
        .D_rs(D_rs), .D_rt(D_rt), .D_T_use_rs(D_T_use_rs), .D_T_use_rt(D_T_use_rt),
        .D_dst(D_dst), .D_regwrite(D_regwrite), .D_T_new(D_T_new), .D_md_op(D_md_op),
        .D_is_eret(D_is_eret), .D_is_mtc0_epc(D_is_mtc0_epc),
        .stall(stall_s), .fwd_rs_sel(fwd_rs_sel_s), .fwd_rt_sel(fwd_rt_sel_s),
        .mdu_busy(mdu_busy_s), .stall_cnt(stall_cnt_s)
    );

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       chk;
        logic       rst;
        logic       rq;
        logic       v;
        logic [4:0] rs;
        logic [1:0] urs;
        logic [4:0] rt;
        logic [1:0] urt;
        logic [4:0] dst;
        logic       rw;
        logic [1:0] tn;
        logic [1:0] md;
        logic       eret;
        logic       epc;
        logic       e_stall;
        logic [1:0] e_rs;
        logic [1:0] e_rt;
        logic       e_busy;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int chk, input int rst, input int rq, input int v,
                       input int rs, input int urs, input int rt, input int urt,
                       input int dst, input int rw, input int tn,
                       input int md, input int eret, input int epc,
                       input int es, input int ers, input int ert, input int eb, input int ec);
        vec_t r;
        r.chk = 1'(chk);  r.rst = 1'(rst);  r.rq = 1'(rq);   r.v = 1'(v);
        r.rs = 5'(rs);    r.urs = 2'(urs);  r.rt = 5'(rt);   r.urt = 2'(urt);
        r.dst = 5'(dst);  r.rw = 1'(rw);    r.tn = 2'(tn);
        r.md = 2'(md);    r.eret = 1'(eret); r.epc = 1'(epc);
        r.e_stall = 1'(es); r.e_rs = 2'(ers); r.e_rt = 2'(ert); r.e_busy = 1'(eb);
        r.e_cnt = ec;
        tbl.push_back(r);
    endtask

    task automatic add_reset();
        add(0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
    endtask

    // ------------------------------------------------------------------
    // Reference model: list of in-flight instructions with their age
    // (cycles since entering E); slot index is age+1.
    // ------------------------------------------------------------------
    typedef struct {
        int         age;
        logic       rw;
        logic [4:0] dst;
        int         t0;
        logic       epc;
    } fl_t;

    fl_t  fl_q[$];
    int   mdu_left;
    int   m_cnt;
    logic m_stall;
    int   m_rs;
    int   m_rt;
    logic m_busy;

    function automatic void youngest(input logic [4:0] src, output int sel, output int rem);
        sel = 0;
        rem = 0;
        foreach (fl_q[i]) begin
            if (fl_q[i].rw && fl_q[i].dst == src && src != 5'd0 &&
                (sel == 0 || fl_q[i].age + 1 < sel)) begin
                sel = fl_q[i].age + 1;
                rem = fl_q[i].t0 - fl_q[i].age;
                if (rem < 0) rem = 0;
            end
        end
    endfunction

    function automatic void model_eval();
        int   rs_rem;
        int   rt_rem;
        logic hz;
        logic er;
        youngest(D_rs, m_rs, rs_rem);
        youngest(D_rt, m_rt, rt_rem);
        er = 1'b0;
        foreach (fl_q[i]) begin
            if (fl_q[i].epc && fl_q[i].age < STAGES - 1) er = 1'b1;
        end
        hz = (m_rs != 0 && rs_rem > int'(D_T_use_rs)) ||
             (m_rt != 0 && rt_rem > int'(D_T_use_rt)) ||
             (D_md_op != 2'b00 && mdu_left > 0) ||
             (D_is_eret && er);
        m_stall = D_valid && !req && hz;
        m_busy  = (mdu_left > 0);
    endfunction

    function automatic void model_update();
        if (reset) begin
            fl_q.delete();
            mdu_left = 0;
            m_cnt    = 0;
        end else begin
            if (m_stall) m_cnt++;
            if (D_valid && !m_stall && !req && D_md_op == 2'b01) mdu_left = 5;
            else if (D_valid && !m_stall && !req && D_md_op == 2'b10) mdu_left = 10;
            else if (mdu_left > 0) mdu_left--;
            if (req) begin
                fl_q.delete();
            end else begin
                foreach (fl_q[i]) fl_q[i].age++;
                for (int i = fl_q.size() - 1; i >= 0; i--) begin
                    if (fl_q[i].age >= STAGES) fl_q.delete(i);
                end
                if (D_valid && !m_stall) begin
                    fl_q.push_back('{0, D_regwrite, D_dst, int'(D_T_new), D_is_mtc0_epc});
                end
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] exp_q[$];
    int    n_checks;
    int    n_err;
    string cur_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %0d expected %0d", cur_tag, name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack_exp(input logic s, input int rs, input int rt,
                                                  input logic b, input int c);
        logic [3:0] c4;
        c4 = (c > 15) ? 4'd15 : 4'(c);
        return {s, 2'(rs), 2'(rt), b, 32'(c), c4};
    endfunction

    // One clock: evaluate model and compare mid-cycle, then advance the model
    // at the rising edge. Table rows supply their own expectations.
    task automatic run_cycle(input logic do_chk, input logic use_model, input logic [EXP_W-1:0] tbl_exp);
        logic [EXP_W-1:0] e;
        @(negedge clk);
        model_eval();
        if (do_chk) begin
            if (use_model) exp_q.push_back(pack_exp(m_stall, m_rs, m_rt, m_busy, m_cnt));
            else           exp_q.push_back(tbl_exp);
            e = exp_q.pop_front();
            check("stall",        32'(stall),        32'(e[41]));
            check("fwd_rs_sel",   32'(fwd_rs_sel),   32'(e[40:39]));
            check("fwd_rt_sel",   32'(fwd_rt_sel),   32'(e[38:37]));
            check("mdu_busy",     32'(mdu_busy),     32'(e[36]));
            check("stall_cnt",    stall_cnt,         e[35:4]);
            check("sat_stall",    32'(stall_s),      32'(e[41]));
            check("sat_fwd_rs",   32'(fwd_rs_sel_s), 32'(e[40:39]));
            check("sat_fwd_rt",   32'(fwd_rt_sel_s), 32'(e[38:37]));
            check("sat_mdu_busy", 32'(mdu_busy_s),   32'(e[36]));
            check("sat_stall_cnt", 32'(stall_cnt_s), 32'(e[3:0]));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive(input vec_t r);
        reset = r.rst;   req = r.rq;     D_valid = r.v;
        D_rs = r.rs;     D_T_use_rs = r.urs;
        D_rt = r.rt;     D_T_use_rt = r.urt;
        D_dst = r.dst;   D_regwrite = r.rw;  D_T_new = r.tn;
        D_md_op = r.md;  D_is_eret = r.eret; D_is_mtc0_epc = r.epc;
    endtask

    task automatic drive_random();
        int md_pick;
        reset      = ($urandom_range(0, 99) == 0);
        req        = ($urandom_range(0, 15) == 0);
        D_valid    = ($urandom_range(0, 3) != 0);
        D_rs       = 5'($urandom_range(0, 3));
        D_rt       = 5'($urandom_range(0, 3));
        D_T_use_rs = 2'($urandom_range(0, 3));
        D_T_use_rt = 2'($urandom_range(0, 3));
        D_dst      = 5'($urandom_range(0, 3));
        D_regwrite = ($urandom_range(0, 3) != 0);
        D_T_new    = 2'($urandom_range(0, 3));
        md_pick    = int'($urandom_range(0, 9));
        D_md_op    = (md_pick <= 5) ? 2'b00 : (md_pick == 6) ? 2'b01 :
                     (md_pick == 7) ? 2'b10 : 2'b11;
        D_is_eret     = ($urandom_range(0, 5) == 0);
        D_is_mtc0_epc = ($urandom_range(0, 5) == 0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t idle;
        n_checks = 0;
        n_err    = 0;
        mdu_left = 0;
        m_cnt    = 0;
        m_stall  = 1'b0;

        idle = '{default: '0};
        idle.rst = 1'b1;
        drive(idle);
        run_cycle(1'b0, 1'b0, '0);
        run_cycle(1'b0, 1'b0, '0);

        // Reset state with hazard-looking D inputs.
        add_reset();
        add(1,0,0,1,  8,0, 9,0,  8,1,3,  3,1,1,  0,0,0,0,0);

        // Load-use: T_new=2 vs T_use=0, then T_new=3 vs T_use=1 on rt.
        add_reset();
        add(1,0,0,1,  0,0, 0,0,  8,1,2,  0,0,0,  0,0,0,0,0);
        add(1,0,0,1,  8,0, 0,0,  9,1,1,  0,0,0,  1,1,0,0,0);
        add(1,0,0,1,  8,0, 0,0,  9,1,1,  0,0,0,  1,2,0,0,1);
        add(1,0,0,1,  8,0, 0,0,  9,1,1,  0,0,0,  0,3,0,0,2);
        add(1,0,0,0,  0,0, 0,0,  0,0,0,  0,0,0,  0,0,0,0,2);
        add(1,0,0,1,  0,0, 0,0,  7,1,3,  0,0,0,  0,0,0,0,2);
        add(1,0,0,1,  9,0, 7,1,  0,0,0,  0,0,0,  1,3,1,0,2);
        add(1,0,0,1,  9,0, 7,1,  0,0,0,  0,0,0,  1,0,2,0,3);
        add(1,0,0,1,  9,0, 7,1,  0,0,0,  0,0,0,  0,0,3,0,4);

        // Zero register never matches; youngest match shadows older ones.
        add_reset();
        add(1,0,0,1,  0,0, 0,0,  0,1,3,  0,0,0,  0,0,0,0,0);
        add(1,0,0,1,  0,0, 0,0,  5,1,2,  0,0,0,  0,0,0,0,0);
        add(1,0,0,1,  0,0, 0,0,  5,1,0,  0,0,0,  0,0,0,0,0);
        add(1,0,0,1,  5,0, 5,0,  0,0,0,  0,0,0,  0,1,1,0,0);
        add(1,0,0,1,  5,0, 0,0,  0,0,0,  0,0,0,  0,2,0,0,0);

        // mult then mfhi: busy and stalled 5 cycles; div then busy 10 cycles.
        add_reset();
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  1,0,0,  0,0,0,0,0);
        for (int i = 0; i < 5; i++) add(1,0,0,1, 0,0,0,0, 10,1,1, 3,0,0, 1,0,0,1,i);
        add(1,0,0,1,  0,0, 0,0, 10,1,1,  3,0,0,  0,0,0,0,5);
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  2,0,0,  0,0,0,0,5);
        for (int i = 0; i < 10; i++) add(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,1,5);
        add(1,0,0,0,  0,0, 0,0,  0,0,0,  0,0,0,  0,0,0,0,5);

        // mtc0 EPC immediately followed by eret: 2 stall cycles.
        add_reset();
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  0,0,1,  0,0,0,0,0);
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  0,1,0,  1,0,0,0,0);
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  0,1,0,  1,0,0,0,1);
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  0,1,0,  0,0,0,0,2);
        add(1,0,0,0,  0,0, 0,0,  0,0,0,  0,0,0,  0,0,0,0,2);

        // req during a load-use stall with a mult running; req on a div in D.
        add_reset();
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  1,0,0,  0,0,0,0,0);
        add(1,0,0,1,  0,0, 0,0,  8,1,2,  0,0,0,  0,0,0,1,0);
        add(1,0,0,1,  8,0, 0,0,  0,0,0,  0,0,0,  1,1,0,1,0);
        add(1,0,1,1,  8,0, 0,0,  0,0,0,  0,0,0,  0,2,0,1,1);
        add(1,0,0,1,  8,0, 0,0,  0,0,0,  0,0,0,  0,0,0,1,1);
        add(1,0,0,0,  0,0, 0,0,  0,0,0,  0,0,0,  0,0,0,1,1);
        add(1,0,1,1,  0,0, 0,0,  0,0,0,  2,0,0,  0,0,0,0,1);
        add(1,0,0,0,  0,0, 0,0,  0,0,0,  0,0,0,  0,0,0,0,1);

        // reset in the middle of a div.
        add_reset();
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  2,0,0,  0,0,0,0,0);
        add(1,0,0,1,  0,0, 0,0, 11,1,1,  3,0,0,  1,0,0,1,0);
        add(1,0,0,1,  0,0, 0,0, 11,1,1,  3,0,0,  1,0,0,1,1);
        add(1,1,0,1,  0,0, 0,0, 11,1,1,  3,0,0,  1,0,0,1,2);
        add(1,0,0,1,  0,0, 0,0, 11,1,1,  3,0,0,  0,0,0,0,0);

        // 20 stall cycles: 4-bit counter holds at 15.
        add_reset();
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  2,0,0,  0,0,0,0,0);
        for (int i = 0; i < 10; i++) add(1,0,0,1, 0,0,0,0, 11,1,1, 3,0,0, 1,0,0,1,i);
        add(1,0,0,1,  0,0, 0,0, 11,1,1,  3,0,0,  0,0,0,0,10);
        add(1,0,0,1,  0,0, 0,0,  0,0,0,  2,0,0,  0,0,0,0,10);
        for (int i = 0; i < 10; i++) add(1,0,0,1, 0,0,0,0, 11,1,1, 3,0,0, 1,0,0,1,10+i);
        add(1,0,0,0,  0,0, 0,0,  0,0,0,  0,0,0,  0,0,0,0,20);
        add(1,0,0,0,  0,0, 0,0,  0,0,0,  0,0,0,  0,0,0,0,20);

        foreach (tbl[i]) begin
            cur_tag = $sformatf("row%0d", i);
            drive(tbl[i]);
            run_cycle(tbl[i].chk, 1'b0,
                      pack_exp(tbl[i].e_stall, int'(tbl[i].e_rs), int'(tbl[i].e_rt),
                               tbl[i].e_busy, tbl[i].e_cnt));
        end

        // Randomized traffic against the model, starting from reset.
        drive(idle);
        run_cycle(1'b0, 1'b0, '0);
        for (int n = 0; n < 3000; n++) begin
            cur_tag = $sformatf("rand%0d", n);
            drive_random();
            run_cycle(1'b1, 1'b1, '0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard and interlock unit for the MIPS core. It keeps its own shift-register scoreboard of in-flight register writes for the stages after D, so the later stages no longer need to export their destination and Tnew. It also runs an internal MDU latency counter and the eret/EPC interlock. From this state and the D-stage operands it produces D-stage `stall`, forwarding-source selects, `mdu_busy` and a saturating stall-cycle counter.

## Interface
Parameters:
- STAGES, 3, number of tracked stages after D (slot 1 = E, slot STAGES = W); legal 2..7
- TNEW_W, 2, width of T_use/T_new fields
- MULT_CYCLES, 5, MDU busy cycles for mult/multu/madd-type ops; ≥1
- DIV_CYCLES, 10, MDU busy cycles for div/divu; ≥1
- CNT_W, 32, stall counter width
- SEL_W = $clog2(STAGES+1), derived; select width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  exception/interrupt flush of D and all tracked slots
- D_valid  in  1  D holds a real instruction
- D_rs, D_rt  in  5  source register numbers
- D_T_use_rs, D_T_use_rt  in  TNEW_W  cycles until operand needed
- D_dst  in  5  destination register
- D_regwrite  in  1  D instruction writes D_dst
- D_T_new  in  TNEW_W  cycles after entering E until result is forwardable
- D_md_op  in  2  00 none, 01 mult-type start, 10 div start, 11 HI/LO access (mf/mt)
- D_is_eret  in  1  D is eret
- D_is_mtc0_epc  in  1  D is mtc0 to CP0 reg 14
- stall  out  1  freeze PC/F/D, inject bubble into E
- fwd_rs_sel, fwd_rt_sel  out  SEL_W  0 = register file, k = slot k
- mdu_busy  out  1  MDU counter non-zero
- stall_cnt  out  CNT_W  cycles with stall=1, saturating

## Operation
- Slot k holds {valid, regwrite, dst, tnew, mtc0_epc}.
- Each cycle, slot k+1 ← slot k with tnew decremented, saturating at 0.
- Slot 1 loading:
  - stall=0 and D_valid=1: slot 1 ← D fields, tnew = D_T_new.
  - stall=1 or D_valid=0: slot 1 ← bubble (valid=0).
- Operand match, per operand (rs and rt): slot k matches if valid & regwrite & dst==operand & operand≠0. Only the youngest matching slot (smallest k) counts; older matches are shadowed.
- Operand stall: youngest match has tnew > T_use.
- fwd_*_sel: index of the youngest match, or 0 if there is none. Reported even while stalling.
- MDU counter:
  - Loads MULT_CYCLES (01) or DIV_CYCLES (10) on the edge where a start op leaves D (stall=0, D_valid=1, req=0).
  - Otherwise decrements while non-zero.
- MDU stall: D_valid & D_md_op≠00 & counter≠0.
- eret stall: D_is_eret and any valid slot 1..STAGES-1 has mtc0_epc. Slot STAGES is excluded because the EPC is written by then.
- stall = D_valid & ~req & (rs | rt | MDU | eret stall).
- req:
  - On the edge, all slots ← invalid and slot 1 does not load D.
  - The MDU counter continues; an op already in E completes. A start op sitting in D is flushed and not loaded.
- stall_cnt increments on each edge with stall=1 and holds at all-ones.

## Timing
- stall, fwd_*_sel and mdu_busy are combinational from registered state plus D inputs. There are no registered outputs except stall_cnt.
- Reset: all slots invalid, MDU counter 0, stall_cnt 0. Consequently stall=0, fwd_*_sel=0 and mdu_busy=0 in the cycle after reset, for any D input.
- reset has priority over req; req has priority over stall.
- Load-use latency: a producer with T_new=t blocks a consumer with T_use=u for max(0, t-u) cycles.
- MDU: busy for exactly MULT_CYCLES/DIV_CYCLES cycles, starting the cycle the op is in E.
- Simultaneous start-op entry and counter decrement: the load wins.
- Reset mid-operation clears everything, including a running MDU count.

## Test plan
- Load-use, STAGES=3:
  - Stimulus: lw dst=8, T_new=2 enters; next D has rs=8, T_use_rs=0.
  - Response: stall=1 for 2 cycles, then stall=0 with fwd_rs_sel=3; stall_cnt=2.
- Zero register and shadowing:
  - Slot 1 writes $0 with tnew=3, consumer rs=0 → stall=0, fwd_rs_sel=0.
  - Slot 1 writes $5 with tnew=0 and slot 2 writes $5 with tnew=1, consumer rt=5 with T_use=0 → stall=0, fwd_rt_sel=1.
- MDU, MULT_CYCLES=5:
  - Stimulus: mult followed by mfhi.
  - Response: mdu_busy=1 for 5 cycles and mfhi stalled 5 cycles; a div restart loads 10.
- eret, STAGES=3:
  - Stimulus: mtc0 EPC immediately followed by eret.
  - Response: stall=1 for 2 cycles, released when mtc0 reaches slot 3.
- Flush and reset:
  - req during a load-use stall → stall=0 that cycle; all slots invalid next cycle; a running MDU count continues.
  - reset mid-div → mdu_busy=0 and stall_cnt=0 next cycle.
- Saturation:
  - CNT_W=4 with a continuous stall of 20 cycles → stall_cnt holds at 15.
